// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-write dual-port RAM: size helpers,
// init FSM states and the byte-merge used by both array writes and read forwarding.
package dpram_pkg;

   // Upper bound on word width handled by byte_merge.
   localparam int MAX_W = 1024;

   typedef enum logic {
      INIT,
      RUN
   } dpram_state_e;

   function automatic int calc_nb(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

   function automatic int calc_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Bit b takes new_w when its byte's active-low mask bit is 0, else keeps old_w.
   function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                   input logic [MAX_W-1:0] new_w,
                                                   input logic [MAX_W-1:0] mask_n,
                                                   input int               bw);
      logic [MAX_W-1:0] res;
      for (int b = 0; b < MAX_W; b++) begin
         res[b] = mask_n[b / bw] ? old_w[b] : new_w[b];
      end
      return res;
   endfunction

endpackage

// File: rtl/dpram_out_stage.sv
// Per-port read path: captures read data on a completed read (holding otherwise),
// plus an optional extra register stage selected by OUT_REG.
module dpram_out_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REG    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  qv
);

   logic [DATA_WIDTH-1:0] q1_q, q1_d;
   logic                  qv1_q, qv1_d;

   always_comb begin
      q1_d  = rd_en ? rd_data : q1_q;
      qv1_d = rd_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q1_q  <= '0;
         qv1_q <= 1'b0;
      end else begin
         q1_q  <= q1_d;
         qv1_q <= qv1_d;
      end
   end

   if (OUT_REG != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] q2_q, q2_d;
      logic                  qv2_q, qv2_d;

      always_comb begin
         q2_d  = q1_q;
         qv2_d = qv1_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q2_q  <= '0;
            qv2_q <= 1'b0;
         end else begin
            q2_q  <= q2_d;
            qv2_q <= qv2_d;
         end
      end

      assign q  = q2_q;
      assign qv = qv2_q;
   end else begin : g_direct
      assign q  = q1_q;
      assign qv = qv1_q;
   end

endmodule

// File: rtl/dpram_bw_sc.sv
// Single-clock true dual-port RAM with byte write enables, same-address merge/forwarding
// and read-valid flags. Define DPRAM_INIT_CLEAR_EN to zero the array after every reset.
module dpram_bw_sc
   import dpram_pkg::*;
#(
   parameter int    DATA_WIDTH    = 32,
   parameter int    BYTE_WIDTH    = 8,
   parameter int    DEPTH         = 1024,
   parameter int    OUT_REG       = 0,
   parameter string RAM_STYLE_VAL = "block",
   localparam int   NB            = calc_nb(DATA_WIDTH, BYTE_WIDTH),
   localparam int   AW            = calc_aw(DEPTH)
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  CENA,
   input  logic                  CENB,
   input  logic                  WENA,
   input  logic                  WENB,
   input  logic [NB-1:0]         BWENA,
   input  logic [NB-1:0]         BWENB,
   input  logic [AW-1:0]         AA,
   input  logic [AW-1:0]         AB,
   input  logic [DATA_WIDTH-1:0] DA,
   input  logic [DATA_WIDTH-1:0] DB,
   output logic [DATA_WIDTH-1:0] QA,
   output logic [DATA_WIDTH-1:0] QB,
   output logic                  QVA,
   output logic                  QVB,
   output logic                  COLL,
   output logic                  BUSY
);

   (* ram_style = RAM_STYLE_VAL *) logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  busy, init_we;
   logic [AW-1:0]         init_addr;
   logic                  a_in, b_in, rd_a, rd_b, wr_a, wr_b, same_addr, coll_ww;
   logic                  we_a, we_b;
   logic [NB-1:0]         wmask_b;
   logic [DATA_WIDTH-1:0] wdata_b, rdata_a, rdata_b;
   logic                  coll_q, coll_d;

   function automatic logic [DATA_WIDTH-1:0] merge_w(input logic [DATA_WIDTH-1:0] old_w,
                                                     input logic [DATA_WIDTH-1:0] new_w,
                                                     input logic [NB-1:0]         mask_n);
      return DATA_WIDTH'(byte_merge(MAX_W'(old_w), MAX_W'(new_w), ~MAX_W'(~mask_n), BYTE_WIDTH));
   endfunction

`ifdef DPRAM_INIT_CLEAR_EN
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   dpram_state_e  state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + AW'(1);
         if (cnt_q == LAST_ADDR) begin
            state_d = RUN;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy      = (state_q == INIT);
   assign init_we   = busy;
   assign init_addr = cnt_q;
`else
   assign busy      = 1'b0;
   assign init_we   = 1'b0;
   assign init_addr = '0;
`endif

   // A same-address write/write collapses onto port B's write with A's bytes on top.
   always_comb begin
      a_in      = 32'(AA) < DEPTH;
      b_in      = 32'(AB) < DEPTH;
      rd_a      = !busy && !CENA && WENA;
      rd_b      = !busy && !CENB && WENB;
      wr_a      = !busy && !CENA && !WENA;
      wr_b      = !busy && !CENB && !WENB;
      same_addr = (AA == AB);
      coll_ww   = wr_a && wr_b && same_addr;
      we_a      = wr_a && a_in && !coll_ww;
      we_b      = wr_b && b_in;
      wmask_b   = coll_ww ? (BWENA & BWENB) : BWENB;
      wdata_b   = coll_ww ? merge_w(DB, DA, BWENA) : DB;
      coll_d    = coll_ww;
      rdata_a   = '0;
      rdata_b   = '0;
      if (a_in) rdata_a = (wr_b && same_addr) ? merge_w(mem[AA], DB, BWENB) : mem[AA];
      if (b_in) rdata_b = (wr_a && same_addr) ? merge_w(mem[AB], DA, BWENA) : mem[AB];
   end

   always_ff @(posedge CLK) begin
      if (init_we) mem[init_addr] <= '0;
      for (int i = 0; i < NB; i++) begin
         if (we_a && !BWENA[i]) mem[AA][i*BYTE_WIDTH +: BYTE_WIDTH] <= DA[i*BYTE_WIDTH +: BYTE_WIDTH];
         if (we_b && !wmask_b[i]) mem[AB][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) coll_q <= 1'b0;
      else        coll_q <= coll_d;
   end

   dpram_out_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_out_a (
      .clk(CLK), .rst_n(RST_N), .rd_en(rd_a), .rd_data(rdata_a), .q(QA), .qv(QVA)
   );

   dpram_out_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_out_b (
      .clk(CLK), .rst_n(RST_N), .rd_en(rd_b), .rd_data(rdata_b), .q(QB), .qv(QVB)
   );

   assign COLL = coll_q;
   assign BUSY = busy;

endmodule

// File: tb/tb_dpram_bw_sc.sv
// Directed bench for dpram_bw_sc: reset, byte masks, collisions, forwarding,
// range/hold, throughput, mid-operation reset and (with DPRAM_INIT_CLEAR_EN) init clear.
module tb_dpram_bw_sc;

   localparam int DW      = 32;
   localparam int BW      = 8;
   localparam int NB      = DW / BW;
   localparam int OUT_REG = 0;
`ifdef DPRAM_INIT_CLEAR_EN
   localparam int   DEPTH    = 16;
   localparam logic BUSY_RST = 1'b1;
`else
   localparam int   DEPTH    = 1000;
   localparam logic BUSY_RST = 1'b0;
`endif
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic          CLK, RST_N;
   logic          CENA, CENB, WENA, WENB;
   logic [NB-1:0] BWENA, BWENB;
   logic [AW-1:0] AA, AB;
   logic [DW-1:0] DA, DB, QA, QB;
   logic          QVA, QVB, COLL, BUSY;

   int n_assert = 0;
   int n_fail   = 0;

   dpram_bw_sc #(
      .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .DEPTH(DEPTH), .OUT_REG(OUT_REG), .RAM_STYLE_VAL("block")
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .CENA(CENA), .CENB(CENB), .WENA(WENA), .WENB(WENB),
      .BWENA(BWENA), .BWENB(BWENB), .AA(AA), .AB(AB), .DA(DA), .DB(DB),
      .QA(QA), .QB(QB), .QVA(QVA), .QVB(QVB), .COLL(COLL), .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic idle_all();
      CENA = 1'b1; WENA = 1'b1; BWENA = '1; AA = '0; DA = '0;
      CENB = 1'b1; WENB = 1'b1; BWENB = '1; AB = '0; DB = '0;
   endtask

   task automatic set_a(input logic wen, input logic [NB-1:0] bwen, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      CENA = 1'b0; WENA = wen; BWENA = bwen; AA = a; DA = d;
   endtask

   task automatic set_b(input logic wen, input logic [NB-1:0] bwen, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      CENB = 1'b0; WENB = wen; BWENB = bwen; AB = a; DB = d;
   endtask

   task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] bwen);
      idle_all(); set_a(1'b0, bwen, a, d); @(negedge CLK); idle_all();
   endtask

   task automatic write_b(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] bwen);
      idle_all(); set_b(1'b0, bwen, a, d); @(negedge CLK); idle_all();
   endtask

   task automatic rd_a_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
      idle_all(); set_a(1'b1, '1, a, '0); @(negedge CLK); idle_all();
      repeat (OUT_REG) @(negedge CLK);
      chk(tag, QA, exp);
      chk1({tag, "_qv"}, QVA, 1'b1);
   endtask

   task automatic rd_b_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
      idle_all(); set_b(1'b1, '1, a, '0); @(negedge CLK); idle_all();
      repeat (OUT_REG) @(negedge CLK);
      chk(tag, QB, exp);
      chk1({tag, "_qv"}, QVB, 1'b1);
   endtask

   task automatic wait_ready();
`ifdef DPRAM_INIT_CLEAR_EN
      for (int i = 0; i < 4 * DEPTH && BUSY; i++) @(negedge CLK);
`endif
      chk1("ready", BUSY, 1'b0);
   endtask

   logic [DW-1:0] bb_data [4];

   initial begin
      bb_data = '{32'h0C0C_1111, 32'h0D0D_2222, 32'h0E0E_3333, 32'h0F0F_4444};
      idle_all();
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_qa", QA, '0);
      chk("rst_qb", QB, '0);
      chk1("rst_qva", QVA, 1'b0);
      chk1("rst_qvb", QVB, 1'b0);
      chk1("rst_coll", COLL, 1'b0);
      chk1("rst_busy", BUSY, BUSY_RST);
      RST_N = 1'b1;
      wait_ready();

      // Basic write on A, read on B, then idle hold.
      write_a(5, 32'hDEAD_BEEF, 4'b0000);
      rd_b_chk(5, 32'hDEAD_BEEF, "basic");
      chk1("basic_qva_idle", QVA, 1'b0);
      @(negedge CLK);
      chk("hold_qb", QB, 32'hDEAD_BEEF);
      chk1("hold_qvb", QVB, 1'b0);

      // Byte mask: bytes 0 and 2 replaced.
      write_a(7, 32'h1122_3344, 4'b0000);
      write_b(7, 32'hAABB_CCDD, 4'b1010);
      rd_a_chk(7, 32'h11BB_33DD, "bytemask");

      // Write/write collision, overlap byte goes to A.
      idle_all();
      set_a(1'b0, 4'b1110, 3, 32'h0000_00FF);
      set_b(1'b0, 4'b0000, 3, 32'hFFFF_FFFF);
      @(negedge CLK); idle_all();
      chk1("coll_pulse", COLL, 1'b1);
      @(negedge CLK);
      chk1("coll_once", COLL, 1'b0);
      rd_a_chk(3, 32'hFFFF_FFFF, "coll_word");
      set_a(1'b0, 4'b1110, 3, 32'h0000_0011);
      set_b(1'b0, 4'b0000, 3, 32'hAABB_CCDD);
      @(negedge CLK); idle_all();
      chk1("coll_pulse2", COLL, 1'b1);
      rd_b_chk(3, 32'hAABB_CC11, "coll_prio");

      // Different-address writes are independent.
      set_a(1'b0, 4'b0000, 10, 32'h0101_0101);
      set_b(1'b0, 4'b0000, 11, 32'h0202_0202);
      @(negedge CLK); idle_all();
      chk1("coll_diff", COLL, 1'b0);
      set_a(1'b1, '1, 10, '0);
      set_b(1'b1, '1, 11, '0);
      @(negedge CLK); idle_all();
      repeat (OUT_REG) @(negedge CLK);
      chk("diff_qa", QA, 32'h0101_0101);
      chk("diff_qb", QB, 32'h0202_0202);

      // Read-during-write forwarding, both directions.
      write_a(9, 32'h0, 4'b0000);
      set_a(1'b0, 4'b0000, 9, 32'h1234_5678);
      set_b(1'b1, '1, 9, '0);
      @(negedge CLK); idle_all();
      chk1("fwd_coll", COLL, 1'b0);
      repeat (OUT_REG) @(negedge CLK);
      chk("fwd_qb", QB, 32'h1234_5678);
      chk1("fwd_qvb", QVB, 1'b1);
      set_b(1'b0, 4'b1100, 9, 32'h0000_ABCD);
      set_a(1'b1, '1, 9, '0);
      @(negedge CLK); idle_all();
      repeat (OUT_REG) @(negedge CLK);
      chk("fwd_part_qa", QA, 32'h1234_ABCD);
      rd_b_chk(9, 32'h1234_ABCD, "fwd_stored");

      // All-ones mask and disabled-port writes change nothing.
      write_a(5, 32'h0, 4'b1111);
      idle_all(); CENA = 1'b1; WENA = 1'b0; BWENA = '0; AA = 5; DA = '0;
      @(negedge CLK); idle_all();
      rd_b_chk(5, 32'hDEAD_BEEF, "noop_write");

      // Back-to-back reads on both ports.
      for (int i = 0; i < 4; i++) write_a(AW'(12 + i), bb_data[i], 4'b0000);
      for (int i = 0; i < 4 + OUT_REG; i++) begin
         idle_all();
         if (i < 4) begin
            set_a(1'b1, '1, AW'(12 + i), '0);
            set_b(1'b1, '1, AW'(15 - i), '0);
         end
         @(negedge CLK);
         if (i >= OUT_REG) begin
            chk("b2b_qa", QA, bb_data[i - OUT_REG]);
            chk("b2b_qb", QB, bb_data[3 - (i - OUT_REG)]);
            chk1("b2b_qva", QVA, 1'b1);
         end
      end
      idle_all();

`ifndef DPRAM_INIT_CLEAR_EN
      // Out-of-range read and write.
      write_a(999, 32'h9999_9999, 4'b0000);
      rd_a_chk(1010, 32'h0, "oor_read");
      write_a(1010, 32'hCAFE_F00D, 4'b0000);
      rd_a_chk(999, 32'h9999_9999, "oor_w_999");
      rd_b_chk(5, 32'hDEAD_BEEF, "oor_w_5");
      @(negedge CLK);
      chk("hold_qa", QA, 32'h9999_9999);
      chk1("hold_qva", QVA, 1'b0);
`endif

      // Reset mid-operation clears outputs at once.
      rd_a_chk(7, 32'h11BB_33DD, "pre_rst");
      RST_N = 1'b0;
      #1;
      chk("mid_rst_qa", QA, '0);
      chk1("mid_rst_qva", QVA, 1'b0);
      @(negedge CLK);
      RST_N = 1'b1;
      wait_ready();
`ifndef DPRAM_INIT_CLEAR_EN
      rd_a_chk(7, 32'h11BB_33DD, "rst_keeps_mem");
`else
      begin
         int busy_cnt;
         logic qv_seen;
         for (int a = 0; a < DEPTH; a++) write_a(AW'(a), 32'hA5A5_0000 | 32'(a), 4'b0000);
         RST_N = 1'b0;
         @(negedge CLK);
         chk1("init_busy_rst", BUSY, 1'b1);
         RST_N = 1'b1;
         busy_cnt = 0;
         qv_seen  = 1'b0;
         for (int i = 0; i < 4 * DEPTH && BUSY; i++) begin
            busy_cnt++;
            idle_all(); set_a(1'b1, '1, 0, '0);
            @(negedge CLK);
            if (QVA) qv_seen = 1'b1;
         end
         idle_all();
         chk("init_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
         chk1("init_no_qv", qv_seen, 1'b0);
         for (int a = 0; a < DEPTH; a++) rd_b_chk(AW'(a), 32'h0, "init_zero");
         for (int a = 0; a < DEPTH; a++) write_a(AW'(a), 32'h5A5A_0000 | 32'(a), 4'b0000);
         RST_N = 1'b0;
         @(negedge CLK);
         RST_N = 1'b1;
         repeat (8) @(negedge CLK);
         RST_N = 1'b0;
         @(negedge CLK);
         RST_N = 1'b1;
         busy_cnt = 0;
         for (int i = 0; i < 4 * DEPTH && BUSY; i++) begin
            busy_cnt++;
            @(negedge CLK);
         end
         chk("init_restart_cycles", 32'(busy_cnt), 32'(DEPTH));
         for (int a = 0; a < DEPTH; a++) rd_a_chk(AW'(a), 32'h0, "restart_zero");
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dpram_bw_sc.md
# dpram_bw_sc

Single-clock, true dual-port RAM with per-byte write enables, defined same-address collision behaviour, read-valid flags and an optional output pipeline stage. It is the parametrised successor to the team's basic dual-port RAM and targets shared buffers between two engines in one clock domain (weight/feature staging, descriptor tables). Port semantics keep the active-low CEN/WEN style, so existing callers port over with minimal change.

## Interface
- DATA_WIDTH, 32: word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: write-enable granularity in bits.
- DEPTH, 1024: number of words; need not be a power of two.
- OUT_REG, 0: 1 adds one registered output stage per port.
- RAM_STYLE_VAL, "block": synthesis RAM style attribute on the array.
- CLK  in  1  sole clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CENA / CENB  in  1  port chip enable, active-low.
- WENA / WENB  in  1  active-low write; 1 = read when enabled.
- BWENA / BWENB  in  NB = DATA_WIDTH/BYTE_WIDTH  byte write enables, active-low; bit i covers byte i.
- AA / AB  in  AW = $clog2(DEPTH)  word address.
- DA / DB  in  DATA_WIDTH  write data.
- QA / QB  out  DATA_WIDTH  read data.
- QVA / QVB  out  1  read data valid; 1-cycle pulse aligned with Q.
- COLL  out  1  write-write same-address collision pulse.
- BUSY  out  1  memory initialisation in progress.

## Operation
- Read: !CEN && WEN. Write: !CEN && !WEN; byte i is written only if BWEN[i]==0. An all-ones BWEN write is a no-op, but it is still an access for the collision check.
- Q holds its last value when no read completes. There is no random fill. QV is low on non-read cycles.
- Out-of-range address (A >= DEPTH): the write is dropped. A read returns all-zero with QV=1.
- Write/write, same address, same cycle: merge byte-wise. Bytes enabled on both ports take A's data. COLL pulses one cycle later.
- Write on one port, read on the other, same address, same cycle: the read returns the post-write word (merged new bytes plus old untouched bytes). COLL is not asserted.
- Different addresses: the ports are fully independent.
- Reset values: QA=QB=0, QVA=QVB=0, COLL=0. BUSY=1 if DPRAM_INIT_CLEAR_EN is defined, else 0. Array contents are unaffected by reset unless the macro is defined.

## Timing
- Read latency is 1+OUT_REG cycles: address and enables are sampled at edge N; Q/QV are valid after edge N+1+OUT_REG.
- Write is visible to any read sampled at edge N+1 or later. Same-edge reads follow the forwarding rule.
- The OUT_REG stage is a plain register with no stall. Back-to-back reads every cycle give full throughput on both ports.
- COLL asserts after edge N+1 for a collision sampled at edge N, independent of OUT_REG.
- RST_N assertion mid-operation immediately clears Q/QV/COLL/BUSY-state. In-flight pipeline reads are discarded.

## Configuration
- DPRAM_INIT_CLEAR_EN defined: two-state FSM, INIT and RUN.
  - Reset enters INIT and BUSY=1.
  - INIT writes zero to one word per cycle at addresses 0..DEPTH-1, using an AW-bit counter.
  - After the DEPTH-th write, the FSM goes to RUN and BUSY=0. BUSY falls exactly DEPTH cycles after the first post-reset edge.
  - While BUSY, all port accesses are ignored and QV stays 0.
  - Reset during INIT restarts from address 0.
- Not defined: no FSM, BUSY tied 0, array contents undefined after power-up. Accesses are accepted from the first edge after RST_N deasserts.

## Structure
- Package dpram_pkg:
  - byte-merge function (old word, new word, active-low mask), used for both the array write and read forwarding;
  - helper functions for NB and AW;
  - FSM state typedef (INIT, RUN).
- Sub-module dpram_out_stage: per-port read-data/valid path with OUT_REG generate; instantiated twice.

## Test plan
- Basic R/W: write 0xDEADBEEF to A=5 via port A; read A=5 on port B next cycle. Expect QB=0xDEADBEEF with QVB high at 1+OUT_REG latency.
- Byte mask: with word 0x11223344 at A=7, port B writes 0xAABBCCDD with BWENB=4'b1010. Expect a readback of 0x11BB33DD.
- Write/write collision: at A=3, port A writes 0x000000FF (BWENA=4'b1110) and port B writes 0xFFFFFFFF (BWENB=4'b0000) in the same cycle. Expect the word to read 0xFFFFFFFF and COLL to pulse once.
- Forwarding: at A=9 holding 0x0, port A writes 0x12345678 while port B reads A=9 in the same cycle. Expect QB=0x12345678 and COLL=0.
- Range and hold: with DEPTH=1000, read at A=1010 gives QA=0 and QVA=1; a write to A=1010 leaves every word unchanged. On idle cycles QA holds its last value and QVA=0.
- Init (macro on, DEPTH=16): preload garbage, pulse RST_N. Expect BUSY high for exactly 16 cycles, reads during BUSY give QV=0, and all 16 words read 0 afterwards. Reassert reset at cycle 8 and expect BUSY to last 16 more cycles.
